// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pkg
// Description : Shared AXI encodings, bridge state constants and a
//               cache-size to AXI-size helper for the SRAM-to-AXI bridges.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    // Cache-side transfer size encodings
    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;

    // AXI response and burst length
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    // Bridge state encoding (kept as plain constants for legacy tools)
    typedef logic [2:0] bridge_state_t;
    localparam bridge_state_t ST_IDLE  = 3'd0;
    localparam bridge_state_t ST_RADDR = 3'd1;
    localparam bridge_state_t ST_RDATA = 3'd2;
    localparam bridge_state_t ST_WADDR = 3'd3;
    localparam bridge_state_t ST_WRESP = 3'd4;

    // Map cache size to AXI AxSIZE; the reserved code 11 behaves as a word
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        logic [2:0] result;
        case (size)
            SIZE_BYTE: result = 3'd0;
            SIZE_HALF: result = 3'd1;
            default:   result = 3'd2;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/d_sram_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : d_sram_axi_bridge_if
// Description : Cache-side SRAM-like port plus AXI master channels of the
//               data-side bridge. Optional bus_err when AXI_RESP_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface d_sram_axi_bridge_if #(
    parameter int ID_WIDTH = 4
);
    // Cache side
    logic                data_req;
    logic                data_wr;
    logic [1:0]          data_size;
    logic [31:0]         data_addr;
    logic [31:0]         data_wdata;
    logic [31:0]         data_rdata;
    logic                data_addr_ok;
    logic                data_data_ok;
    // AR / R
    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic                arvalid;
    logic                arready;
    logic [ID_WIDTH-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    // AW / W / B
    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic                awvalid;
    logic                awready;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
`ifdef AXI_RESP_CHECK_EN
    logic                bus_err;
`endif

    // Bridge view: serves the cache, masters the AXI bus
    modport master (
`ifdef AXI_RESP_CHECK_EN
        output bus_err,
`endif
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok,
        output arid, araddr, arlen, arsize, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    // Environment view: the cache plus the AXI slave
    modport slave (
`ifdef AXI_RESP_CHECK_EN
        input  bus_err,
`endif
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok,
        input  arid, araddr, arlen, arsize, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface
`default_nettype wire

// File: rtl/axi_strb_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_strb_gen
// Description : Combinational byte-strobe generator from transfer size and
//               the low address bits.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_strb_gen
    import axi_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_strb
);

    // Select the lanes covered by the access; code 11 covers the full word
    always_comb begin
        o_strb = 4'b1111;
        case (i_size)
            SIZE_BYTE: o_strb = 4'b0001 << i_addr_lo;
            SIZE_HALF: o_strb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: o_strb = 4'b1111;
            default:   o_strb = 4'b1111;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/d_sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : d_sram_axi_bridge
// Description : Data-cache SRAM-like port to single-beat AXI bridge, one
//               outstanding transaction. Optional macro AXI_RESP_CHECK_EN adds
//               a sticky bus_err flag for non-OKAY responses.
// Revision    : 1.0 - initial release
// ============================================================================
module d_sram_axi_bridge
    import axi_pkg::*;
#(
    parameter int                  ID_WIDTH = 4,
    parameter logic [ID_WIDTH-1:0] AXI_ID   = ID_WIDTH'(1)
)(
    input  logic                  clk,
    input  logic                  rst,
    d_sram_axi_bridge_if.master   bus
);

    bridge_state_t state_q, state_d;
    logic [31:0]   addr_q,  addr_d;
    logic [2:0]    size_q,  size_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q,  w_done_d;

    logic [3:0]    w_strb;
    logic          w_aw_fin;
    logic          w_w_fin;
    logic          w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready;
    logic          w_addr_ok, w_data_ok;

    axi_strb_gen u_strb_gen (
        .i_size    (bus.data_size),
        .i_addr_lo (bus.data_addr[1:0]),
        .o_strb    (w_strb)
    );

    // Transaction sequencing: capture in IDLE, then address and response phases
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        w_aw_fin  = 1'b0;
        w_w_fin   = 1'b0;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        w_addr_ok = 1'b0;
        w_data_ok = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.data_req) begin
                    addr_d    = bus.data_addr;
                    size_d    = axi_size(bus.data_size);
                    wdata_d   = bus.data_wdata;
                    wstrb_d   = w_strb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = bus.data_wr ? ST_WADDR : ST_RADDR;
                end
            end
            ST_RADDR: begin
                w_arvalid = 1'b1;
                if (bus.arready) begin
                    w_addr_ok = 1'b1;
                    state_d   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                w_rready = 1'b1;
                if (bus.rvalid) begin
                    w_data_ok = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WADDR: begin
                // AW and W retire independently; accept once both have gone
                w_awvalid = ~aw_done_q;
                w_wvalid  = ~w_done_q;
                w_aw_fin  = aw_done_q | bus.awready;
                w_w_fin   = w_done_q  | bus.wready;
                if (w_aw_fin && w_w_fin) begin
                    w_addr_ok = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WRESP;
                end else begin
                    aw_done_d = w_aw_fin;
                    w_done_d  = w_w_fin;
                end
            end
            ST_WRESP: begin
                w_bready = 1'b1;
                if (bus.bvalid) begin
                    w_data_ok = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and captured request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= 32'd0;
            size_q    <= 3'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

`ifdef AXI_RESP_CHECK_EN
    logic bus_err_q, bus_err_d;

    // Sticky flag for any non-OKAY response seen on a completed handshake
    always_comb begin
        bus_err_d = bus_err_q;
        if ((state_q == ST_RDATA) && bus.rvalid && (bus.rresp != RESP_OKAY))
            bus_err_d = 1'b1;
        if ((state_q == ST_WRESP) && bus.bvalid && (bus.bresp != RESP_OKAY))
            bus_err_d = 1'b1;
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus_err_q <= 1'b0;
        else     bus_err_q <= bus_err_d;
    end

    assign bus.bus_err = bus_err_q;
`else
    logic w_unused_resp;
    assign w_unused_resp = ^{bus.rresp, bus.bresp};
`endif

    // Single-beat transfers only; the read ID and last flag carry no information
    logic w_unused_rsig;
    assign w_unused_rsig = ^{bus.rid, bus.rlast};

    assign bus.arid         = AXI_ID;
    assign bus.araddr       = addr_q;
    assign bus.arlen        = LEN_SINGLE;
    assign bus.arsize       = size_q;
    assign bus.arvalid      = w_arvalid;
    assign bus.rready       = w_rready;
    assign bus.awid         = AXI_ID;
    assign bus.awaddr       = addr_q;
    assign bus.awlen        = LEN_SINGLE;
    assign bus.awsize       = size_q;
    assign bus.awvalid      = w_awvalid;
    assign bus.wdata        = wdata_q;
    assign bus.wstrb        = wstrb_q;
    assign bus.wlast        = 1'b1;
    assign bus.wvalid       = w_wvalid;
    assign bus.bready       = w_bready;
    assign bus.data_addr_ok = w_addr_ok;
    assign bus.data_data_ok = w_data_ok;
    assign bus.data_rdata   = bus.rdata;

endmodule
`default_nettype wire

// File: tb/tb_d_sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_d_sram_axi_bridge
// Description : Self-checking bench for d_sram_axi_bridge: directed cases
//               followed by randomized transactions against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d_sram_axi_bridge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    d_sram_axi_bridge_if #(.ID_WIDTH(4)) bus ();

    d_sram_axi_bridge #(
        .ID_WIDTH (4),
        .AXI_ID   (4'd1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    logic model_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Lanes touched by an access: naturally aligned block of 2**size bytes
    function automatic logic [3:0] ref_strb(input logic [1:0] size, input logic [31:0] addr);
        int nbytes;
        int start;
        logic [3:0] s;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        start  = ((int'(addr % 4)) / nbytes) * nbytes;
        s = 4'd0;
        for (int i = 0; i < 4; i++)
            if (i >= start && i < start + nbytes) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [2:0] ref_axsize(input logic [1:0] size);
        return (size == 2'd3) ? 3'd2 : {1'b0, size};
    endfunction

    task automatic idle_inputs();
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd0;
        bus.data_addr  = 32'd0;
        bus.data_wdata = 32'd0;
        bus.arready    = 1'b0;
        bus.rid        = 4'd0;
        bus.rdata      = 32'd0;
        bus.rresp      = 2'd0;
        bus.rlast      = 1'b1;
        bus.rvalid     = 1'b0;
        bus.awready    = 1'b0;
        bus.wready     = 1'b0;
        bus.bresp      = 2'd0;
        bus.bvalid     = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_arvalid"}, bus.arvalid, 1'b0);
        check({tag, "_awvalid"}, bus.awvalid, 1'b0);
        check({tag, "_wvalid"},  bus.wvalid,  1'b0);
        check({tag, "_rready"},  bus.rready,  1'b0);
        check({tag, "_bready"},  bus.bready,  1'b0);
        check({tag, "_addr_ok"}, bus.data_addr_ok, 1'b0);
        check({tag, "_data_ok"}, bus.data_data_ok, 1'b0);
    endtask

    // Called at a negedge; returns at the negedge of the first post-IDLE cycle
    task automatic request(input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus.data_req   = 1'b1;
        bus.data_wr    = wr;
        bus.data_size  = size;
        bus.data_addr  = addr;
        bus.data_wdata = wdata;
        #1;
        check_quiet("idle");
        @(negedge clk);
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'($urandom);
        bus.data_size  = 2'($urandom);
        bus.data_addr  = $urandom;
        bus.data_wdata = $urandom;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [1:0] size,
                           input int ar_d, input int r_d,
                           input logic [31:0] rdata, input logic [1:0] rresp);
        request(1'b0, size, addr, $urandom);
        for (int k = 0; k <= ar_d; k++) begin
            bus.arready = (k == ar_d);
            #1;
            check("ar_valid", bus.arvalid, 1'b1);
            check("ar_addr",  bus.araddr,  addr);
            check("ar_size",  bus.arsize,  ref_axsize(size));
            check("ar_len",   bus.arlen,   8'd0);
            check("ar_id",    bus.arid,    4'd1);
            check("rd_addr_ok", bus.data_addr_ok, (k == ar_d));
            check("rd_early_data_ok", bus.data_data_ok, 1'b0);
            @(negedge clk);
        end
        bus.arready = 1'b0;
        for (int j = 0; j <= r_d; j++) begin
            bus.rvalid = (j == r_d);
            bus.rdata  = (j == r_d) ? rdata : $urandom;
            bus.rresp  = (j == r_d) ? rresp : 2'd0;
            #1;
            check("r_ready",     bus.rready,  1'b1);
            check("r_arvalid",   bus.arvalid, 1'b0);
            check("rd_addr_ok2", bus.data_addr_ok, 1'b0);
            check("rd_data_ok",  bus.data_data_ok, (j == r_d));
            if (j == r_d) begin
                check("rd_rdata", bus.data_rdata, rdata);
                if (rresp != 2'd0) model_err = 1'b1;
            end
            @(negedge clk);
        end
        bus.rvalid = 1'b0;
        bus.rresp  = 2'd0;
        #1;
        check_quiet("rd_done");
`ifdef AXI_RESP_CHECK_EN
        check("rd_bus_err", bus.bus_err, model_err);
`endif
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wdata, input int aw_d, input int w_d,
                            input int b_d, input logic [1:0] bresp);
        int n;
        n = (aw_d > w_d) ? aw_d : w_d;
        request(1'b1, size, addr, wdata);
        for (int k = 0; k <= n; k++) begin
            bus.awready = (k == aw_d);
            bus.wready  = (k == w_d);
            #1;
            check("aw_valid", bus.awvalid, (k <= aw_d));
            check("w_valid",  bus.wvalid,  (k <= w_d));
            check("aw_addr",  bus.awaddr,  addr);
            check("aw_size",  bus.awsize,  ref_axsize(size));
            check("aw_len",   bus.awlen,   8'd0);
            check("aw_id",    bus.awid,    4'd1);
            check("w_data",   bus.wdata,   wdata);
            check("w_strb",   bus.wstrb,   ref_strb(size, addr));
            check("w_last",   bus.wlast,   1'b1);
            check("wr_addr_ok", bus.data_addr_ok, (k == n));
            check("wr_early_data_ok", bus.data_data_ok, 1'b0);
            @(negedge clk);
        end
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        for (int j = 0; j <= b_d; j++) begin
            bus.bvalid = (j == b_d);
            bus.bresp  = (j == b_d) ? bresp : 2'd0;
            #1;
            check("b_ready",     bus.bready,  1'b1);
            check("b_awvalid",   bus.awvalid, 1'b0);
            check("b_wvalid",    bus.wvalid,  1'b0);
            check("wr_addr_ok2", bus.data_addr_ok, 1'b0);
            check("wr_data_ok",  bus.data_data_ok, (j == b_d));
            if (j == b_d && bresp != 2'd0) model_err = 1'b1;
            @(negedge clk);
        end
        bus.bvalid = 1'b0;
        bus.bresp  = 2'd0;
        #1;
        check_quiet("wr_done");
`ifdef AXI_RESP_CHECK_EN
        check("wr_bus_err", bus.bus_err, model_err);
`endif
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("reset");
        check("reset_araddr", bus.araddr, 32'd0);
        check("reset_wdata",  bus.wdata,  32'd0);
        check("reset_wstrb",  bus.wstrb,  4'd0);
        check("reset_awsize", bus.awsize, 3'd0);
`ifdef AXI_RESP_CHECK_EN
        check("reset_bus_err", bus.bus_err, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Word read with arready after 2 cycles, data one cycle later
        do_read(32'h1FC0_0004, 2'b10, 2, 1, 32'hDEAD_BEEF, 2'b00);
        // Byte write at the top lane, AW and W accepted together
        do_write(32'h8000_0003, 2'b00, 32'hAB00_0000, 0, 0, 1, 2'b00);
        // Half write, W accepted three cycles before AW
        do_write(32'h0000_0002, 2'b01, 32'h1234_0000, 3, 0, 0, 2'b00);
        // AW accepted before W
        do_write(32'h0000_0101, 2'b00, 32'h0000_5A00, 0, 2, 2, 2'b00);

        // Reset asserted asynchronously while waiting in the read data phase
        @(negedge clk);
        request(1'b0, 2'b10, 32'h0000_0040, 32'd0);
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        #1;
        check("rst_pre_rready", bus.rready, 1'b1);
        #1;
        rst = 1'b1;
        model_err = 1'b0;
        #1;
        check_quiet("rst_mid");
        check("rst_mid_araddr", bus.araddr, 32'd0);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h0BAD_0BAD;
        #1;
        check("rst_mid_no_data_ok", bus.data_data_ok, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.rvalid = 1'b0;
        #1;
        check_quiet("rst_release");
        @(negedge clk);
        do_read(32'h0000_0080, 2'b01, 0, 0, 32'h5555_AAAA, 2'b00);

        // Error write response, then an OKAY read; flag must persist
        @(negedge clk);
        do_write(32'h0000_0010, 2'b10, 32'hCAFE_F00D, 1, 1, 0, 2'b10);
        do_read(32'h0000_0014, 2'b10, 0, 0, 32'h1111_2222, 2'b00);
`ifdef AXI_RESP_CHECK_EN
        @(negedge clk);
        rst = 1'b1;
        model_err = 1'b0;
        #1;
        check("err_cleared_by_rst", bus.bus_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
`endif

        // Randomized back-to-back transactions
        @(negedge clk);
        for (int t = 0; t < 24; t++) begin
            logic        wr;
            logic [1:0]  sz;
            logic [31:0] a;
            logic [1:0]  rsp;
            wr  = 1'($urandom);
            sz  = 2'($urandom);
            a   = $urandom;
            rsp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (wr)
                do_write(a, sz, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), rsp);
            else
                do_read(a, sz, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, rsp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
